// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and constants for the two-port RAM arbiter.
//                Selection enum, read-return tag and the pipe depth ceiling.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

    // Which requester owns an access
    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    // Read-return tag carried alongside the RAM read latency
    typedef struct packed {
        logic vld;
        sel_t owner;
    } rd_tag_t;

    // Deepest supported RAM read latency
    localparam int RD_LAT_MAX = 4;

    // Empty pipe slot
    localparam rd_tag_t TAG_NONE = '{vld: 1'b0, owner: SEL_A};

    // Round-robin helper: the side that did not win last time
    function automatic sel_t other_side(input sel_t s);
        return (s == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : DEPTH-stage shift register of read tags. Each slot records
//                whether a RAM read was issued that cycle and who owns it, so
//                the tag emerges together with the RAM read data.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule : rd_tag_pipe
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one single-port synchronous RAM between requesters A
//                and B. Round-robin grant each cycle, RAM pin mux from the
//                winner, read data steered back to its owner after RD_LAT.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    // requester A
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] adr_a,
    input  logic [DW-1:0] din_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    // requester B
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] adr_b,
    input  logic [DW-1:0] din_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    // RAM pins
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // Out-of-range latencies are clamped so the tag pipe always elaborates
    localparam int C_PIPE_DEPTH = (RD_LAT < 1)          ? 1 :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    sel_t          last_sel_q;
    sel_t          last_sel_d;
    logic          w_gnt_a;
    logic          w_gnt_b;
    rd_tag_t       w_tag_in;
    rd_tag_t       w_tag_out;
    logic          w_rvalid_a;
    logic          w_rvalid_b;
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_a_d;
    logic [DW-1:0] rdata_b_q;
    logic [DW-1:0] rdata_b_d;

    // Round-robin arbitration: a lone request wins at once, a tie goes to
    // the side that was not served last; nothing is granted while in reset
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && req_b) begin
                if (other_side(last_sel_q) == SEL_A) begin
                    w_gnt_a = 1'b1;
                end else begin
                    w_gnt_b = 1'b1;
                end
            end else if (req_a) begin
                w_gnt_a = 1'b1;
            end else if (req_b) begin
                w_gnt_b = 1'b1;
            end
        end
    end

    // Remember the most recently served side; idle cycles keep history
    always_comb begin
        last_sel_d = last_sel_q;
        if (w_gnt_a) begin
            last_sel_d = SEL_A;
        end else if (w_gnt_b) begin
            last_sel_d = SEL_B;
        end
    end

    // Last-served register; starts at B so the first tie goes to A
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel_q <= SEL_B;
        end else begin
            last_sel_q <= last_sel_d;
        end
    end

    // RAM pin mux from the granted side; all pins parked low when idle
    always_comb begin
        ram_ce  = 1'b0;
        ram_we  = 1'b0;
        ram_adr = '0;
        ram_din = '0;
        if (w_gnt_a) begin
            ram_ce  = 1'b1;
            ram_we  = we_a;
            ram_adr = adr_a;
            ram_din = din_a;
        end else if (w_gnt_b) begin
            ram_ce  = 1'b1;
            ram_we  = we_b;
            ram_adr = adr_b;
            ram_din = din_b;
        end
    end

    // Tag every issued read with its owner; writes push an empty slot
    always_comb begin
        w_tag_in       = TAG_NONE;
        w_tag_in.vld   = ram_ce && !ram_we;
        w_tag_in.owner = w_gnt_b ? SEL_B : SEL_A;
    end

    rd_tag_pipe #(
        .DEPTH (C_PIPE_DEPTH)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (w_tag_in),
        .tag_o (w_tag_out)
    );

    // Steer returning data to its owner; each side keeps its last read value
    always_comb begin
        w_rvalid_a = !rst && w_tag_out.vld && (w_tag_out.owner == SEL_A);
        w_rvalid_b = !rst && w_tag_out.vld && (w_tag_out.owner == SEL_B);
        rdata_a_d  = w_rvalid_a ? ram_dout : rdata_a_q;
        rdata_b_d  = w_rvalid_b ? ram_dout : rdata_b_q;
    end

    // Hold registers for the per-side read data
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign gnt_a    = w_gnt_a;
    assign gnt_b    = w_gnt_b;
    assign rvalid_a = w_rvalid_a;
    assign rvalid_b = w_rvalid_b;
    assign rdata_a  = rdata_a_d;
    assign rdata_b  = rdata_b_d;

endmodule : ram_port_arbiter
`default_nettype wire
